bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential 3-digit BCD to 10-bit unsigned binary converter. Uses the reverse double-dabble algorithm: shift right, then subtract 3 from any BCD digit at or above 8. It is the inverse of the team's binary-to-BCD converter and uses the same start/ready/done handshake. Sits between the board inputs (DIP switches or buttons entered as decimal digits) and downstream binary arithmetic, such as the int-to-float path.

Parameters:
None. Widths are fixed: 3 BCD digits, 10-bit result, 10 iterations.

Ports:
clk    input   1   system clock; all state changes on the rising edge
reset  input   1   asynchronous, active-high reset
start  input   1   request a conversion; sampled only while ready=1
bcd2   input   4   hundreds digit
bcd1   input   4   tens digit
bcd0   input   4   units digit
ready  output  1   high while idle and able to accept start
done   output  1   one-cycle pulse when bin holds a new result
bin    output  10  converted result, registered
err    output  1   invalid-digit flag (see Optional Feature); constant 0 when the feature is compiled out

Behaviour:
- Reset (asynchronous, active-high):
  - state=idle; ready=1, done=0, bin=0, err=0.
  - Shift register and counter are cleared.
  - Reset mid-conversion aborts it; no done pulse is produced.
- States: idle, op, done_st.
- idle:
  - ready=1.
  - On an edge with start=1, load the 22-bit shift register s={bcd2,bcd1,bcd0,10'b0} and set counter n=10.
  - Go to op.
  - start=0: stay in idle.
- op:
  - ready=0.
  - Each edge performs one iteration:
    - s=s>>1 (logical, zero fill at the MSB).
    - Then, for each 4-bit field s[21:18], s[17:14], s[13:10]: if the field is >=8, subtract 3 from it. The three fields are corrected in parallel in the same cycle.
  - n decrements once per iteration.
  - On the edge where the 10th iteration completes:
    - bin <= final s[9:0].
    - Go to done_st.
- done_st:
  - done=1 for exactly one cycle; ready=0.
  - Next edge goes to idle.
- Latency:
  - start sampled at edge E0; iterations on E1..E10.
  - done is high in the cycle between E10 and E11.
  - ready returns to 1 after E11.
  - Throughput: one conversion per 12 cycles.
- bin holds its value between conversions and changes only at completion. It never shows intermediate shift values.
- bcd inputs are captured at start; input changes during op or done_st are ignored.
- start while ready=0 is ignored and not queued.
- start held high continuously: a new conversion begins on the first idle edge after each done pulse.
- For valid digits (each 0..9), after completion the BCD fields of s are all zero and bin equals 100*bcd2 + 10*bcd1 + bcd0 (range 0..999).
- With invalid digits (>9) and the feature compiled out, bin is unspecified. The bench must not check it.

Optional Feature:
Macro: BCD_INVALID_CHK_EN
- Defined:
  - At start, if any of bcd2/bcd1/bcd0 is >9, the block skips op and goes directly to done_st on the next edge.
  - It sets bin=0 and err=1; done pulses the cycle after E0.
  - err is registered and holds until the next accepted start clears it (err=0 on any valid conversion).
- Not defined:
  - No digit check; err is tied to 0.
  - All inputs go through the full 10-iteration conversion.

Test Plan:
- Reset then idle -> ready=1, done=0, bin=0, err=0; start=1 with 9,9,9 -> done high exactly 11 cycles after the start edge, bin=999 (10'h3E7), ready=1 the following cycle.
- Conversions of 0,0,0 / 5,1,2 / 1,0,0 / 0,0,7 -> bin = 0, 512 (10'h200), 100 (10'h064), 7; exactly one done pulse each.
- Start 4,5,6; change the bcd inputs to 9,9,9 and pulse start during op -> bin=456, only one done pulse, second start ignored.
- Start 9,9,9; assert reset 5 cycles later -> no done pulse; bin=0 and ready=1 immediately; a fresh start with 0,4,2 -> bin=42.
- start held high for 40 cycles with 3,2,1 -> done pulses every 12 cycles, bin=321 each time.
- BCD_INVALID_CHK_EN defined: start with 1,10,3 -> done one cycle after the start edge, bin=0, err=1; next start with 0,1,0 -> bin=10, err=0.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble, 10 iterations).
// Optional invalid-digit detection is enabled by defining BCD_INVALID_CHK_EN.
module bcd_to_bin (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic       ready,
  output logic       done,
  output logic [9:0] bin,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

  state_e      state_q, state_d;
  logic [21:0] shift_q, shift_d;
  logic [21:0] shifted, iter;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bin_q, bin_d;

  function automatic logic [3:0] fix_digit(input logic [3:0] f);
    return (f >= 4'd8) ? f - 4'd3 : f;
  endfunction

  // One iteration: logical right shift, then correct all three BCD fields in parallel.
  always_comb begin
    shifted = shift_q >> 1;
    iter    = {fix_digit(shifted[21:18]), fix_digit(shifted[17:14]),
               fix_digit(shifted[13:10]), shifted[9:0]};
  end

`ifdef BCD_INVALID_CHK_EN
  logic err_q, err_d;
  logic bad_digit;

  assign bad_digit = (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
`ifdef BCD_INVALID_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = {bcd2, bcd1, bcd0, 10'b0};
          cnt_d   = 4'd10;
          state_d = StOp;
`ifdef BCD_INVALID_CHK_EN
          err_d   = 1'b0;
          // Invalid digits skip the iterations and report a zero result.
          if (bad_digit) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StOp: begin
        shift_d = iter;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          bin_d   = iter[9:0];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
    end
  end

`ifdef BCD_INVALID_CHK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StDone);
  assign bin   = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized self-checking bench for bcd_to_bin against an arithmetic decimal model.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] bcd2, bcd1, bcd0;
  logic       ready, done, err;
  logic [9:0] bin;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  bcd_to_bin dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bcd2  (bcd2),
    .bcd1  (bcd1),
    .bcd0  (bcd0),
    .ready (ready),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_value(input int d2, input int d1, input int d0);
    return 100 * d2 + 10 * d1 + d0;
  endfunction

  // Starts one conversion and reports how many negedges after the start edge done appeared.
  task automatic run_conv(input int d2, input int d1, input int d0, output int lat);
    @(negedge clk);
    bcd2  = 4'(d2);
    bcd1  = 4'(d1);
    bcd0  = 4'(d0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic conv_check(input string tag, input int d2, input int d1, input int d0,
                            input int exp_lat, input bit chk_bin);
    int lat;
    int base;
    base = done_cnt;
    run_conv(d2, d1, d0, lat);
    check({tag, "_lat"}, lat, exp_lat);
    if (chk_bin) check({tag, "_bin"}, int'(bin), ref_value(d2, d1, d0));
    check({tag, "_busy"}, int'(ready), 0);
    @(negedge clk);
    check({tag, "_ready"}, int'(ready), 1);
    check({tag, "_pulse"}, done_cnt - base, 1);
  endtask

  initial begin
    int lat;
    int base;
    int hits;
    int d2, d1, d0;
    reset = 1'b1;
    start = 1'b0;
    bcd2  = '0;
    bcd1  = '0;
    bcd0  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_bin", int'(bin), 0);
    check("rst_err", int'(err), 0);

    conv_check("c999", 9, 9, 9, 11, 1);
    conv_check("c000", 0, 0, 0, 11, 1);
    conv_check("c512", 5, 1, 2, 11, 1);
    conv_check("c100", 1, 0, 0, 11, 1);
    conv_check("c007", 0, 0, 7, 11, 1);

    for (int i = 0; i < 25; i++) begin
      d2 = int'($urandom_range(0, 9));
      d1 = int'($urandom_range(0, 9));
      d0 = int'($urandom_range(0, 9));
      conv_check("rnd", d2, d1, d0, 11, 1);
      check("rnd_err", int'(err), 0);
    end

    // Inputs changing and start pulsing mid-conversion must be ignored.
    base = done_cnt;
    @(negedge clk);
    {bcd2, bcd1, bcd0} = {4'd4, 4'd5, 4'd6};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    {bcd2, bcd1, bcd0} = {4'd9, 4'd9, 4'd9};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("midop_done_seen", int'(done), 1);
    check("midop_bin", int'(bin), 456);
    repeat (15) @(negedge clk);
    check("midop_pulses", done_cnt - base, 1);

    // Reset in the middle of a conversion aborts it.
    @(negedge clk);
    {bcd2, bcd1, bcd0} = {4'd9, 4'd9, 4'd9};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_bin", int'(bin), 0);
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    base = done_cnt;
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt - base, 0);
    conv_check("c042", 0, 4, 2, 11, 1);

    // Start held high: a new conversion every 12 cycles.
    @(negedge clk);
    {bcd2, bcd1, bcd0} = {4'd3, 4'd2, 4'd1};
    start = 1'b1;
    hits = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        hits++;
        check("held_pos", i, 11 + 12 * (hits - 1));
        check("held_bin", int'(bin), 321);
      end
    end
    start = 1'b0;
    check("held_hits", hits, 3);
    repeat (14) @(negedge clk);
    check("held_idle", int'(ready), 1);

`ifdef BCD_INVALID_CHK_EN
    conv_check("inv", 1, 10, 3, 1, 0);
    check("inv_bin", int'(bin), 0);
    check("inv_err", int'(err), 1);
    conv_check("c010", 0, 1, 0, 11, 1);
    check("c010_err", int'(err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
